hex_keypad_entry: RTL and testbench

HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 rtl/hex_keypad_entry.sv | 83 ++++++++
 tb/tb_hex_keypad_entry.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the hex keypad entry block: scanner states,
// the key-code type, the digit capacity and column-decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] key_code_t;

  // True when exactly one column line is pulled low (a single, unambiguous key)
  function automatic logic col_single_low(input logic [3:0] c);
    logic single;
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single = 1'b1;
      default:                            single = 1'b0;
    endcase
    return single;
  endfunction

  // Position of the low column line; only meaningful when col_single_low holds
  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Keypad scanner: scan-tick divider, active-low row drive and the
// SCAN/DEBOUNCE/HELD/RELEASE state machine producing one key_valid per press.
// Define KEYPAD_COL_SYNC_EN to pass col through a two-flop synchronizer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code
);

  // Stable counter only needs to reach DEBOUNCE_SCANS-1 before the accepting tick
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CNT_W-1:0] LP_STABLE_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [SCAN_DIV_BITS-1:0] r_div;
  logic                     w_tick;
  logic [3:0]               w_col;

  scan_state_t      r_state, w_state_next;
  logic [1:0]       r_row_idx, w_row_idx_next;
  logic [CNT_W-1:0] r_stable, w_stable_next;
  logic [3:0]       r_latched_col, w_latched_next;
  logic             r_key_valid, w_key_valid_next;
  key_code_t        r_key_code, w_key_code_next;

`ifdef KEYPAD_COL_SYNC_EN
  logic [3:0] r_col_meta;
  logic [3:0] r_col_sync;

  // Two-flop synchronizer; idles at all-high so reset looks like "no key"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= 4'b1111;
      r_col_sync <= 4'b1111;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
    end
  end

  assign w_col = r_col_sync;
`else
  assign w_col = col;
`endif

  // Free-running divider; the tick is the cycle the counter is about to wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = &r_div;

  // Next-state logic: everything only moves on a scan tick
  always_comb begin
    w_state_next     = r_state;
    w_row_idx_next   = r_row_idx;
    w_stable_next    = r_stable;
    w_latched_next   = r_latched_col;
    w_key_valid_next = 1'b0;
    w_key_code_next  = r_key_code;
    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (col_single_low(w_col)) begin
            w_latched_next = w_col;
            w_stable_next  = '0;
            w_state_next   = ST_DEBOUNCE;
          end else begin
            w_row_idx_next = r_row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_col == r_latched_col) begin
            if (r_stable == LP_STABLE_LAST) begin
              w_key_valid_next = 1'b1;
              w_key_code_next  = {r_row_idx, col_index(r_latched_col)};
              w_stable_next    = '0;
              w_state_next     = ST_HELD;
            end else begin
              w_stable_next = r_stable + 1'b1;
            end
          end else begin
            w_stable_next = '0;
            w_state_next  = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (w_col == 4'b1111) begin
            w_stable_next = '0;
            w_state_next  = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_col == 4'b1111) begin
            if (r_stable == LP_STABLE_LAST) begin
              w_stable_next = '0;
              w_state_next  = ST_SCAN;
            end else begin
              w_stable_next = r_stable + 1'b1;
            end
          end else begin
            w_stable_next = '0;
            w_state_next  = ST_HELD;
          end
        end
        default: begin
          w_stable_next = '0;
          w_state_next  = ST_SCAN;
        end
      endcase
    end
  end

  // State register for the scanner and its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_SCAN;
      r_row_idx     <= 2'd0;
      r_stable      <= '0;
      r_latched_col <= 4'b1111;
      r_key_valid   <= 1'b0;
      r_key_code    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_row_idx     <= w_row_idx_next;
      r_stable      <= w_stable_next;
      r_latched_col <= w_latched_next;
      r_key_valid   <= w_key_valid_next;
      r_key_code    <= w_key_code_next;
    end
  end

  assign row       = ~(4'b0001 << r_row_idx);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

endmodule

// File: rtl/hex_keypad_entry.sv
// Hex keypad instruction entry: collects up to eight hex digits from the
// scanner into a 32-bit word and offers it through a valid/ready handshake.
// Define KEYPAD_COL_SYNC_EN to synchronize col inside the scanner.
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clear,
  input  logic        commit,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [3:0]  digit_count,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam logic [3:0] LP_NUM_DIGITS = 4'(NUM_DIGITS);

  logic        w_key_valid;
  key_code_t   w_key_code;
  logic        w_accept;
  logic        w_take;
  logic        w_clear;
  logic        w_commit;
  logic [31:0] r_instruction;
  logic [3:0]  r_digit_count;
  logic        r_instr_valid;

  keypad_scanner #(
    .SCAN_DIV_BITS  (SCAN_DIV_BITS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_valid (w_key_valid),
    .key_code  (w_key_code)
  );

  // Digits are only taken while the buffer is open and has room
  assign w_accept = w_key_valid && !r_instr_valid && (r_digit_count < LP_NUM_DIGITS);
  assign w_take   = r_instr_valid && instr_ready;
  assign w_clear  = clear && !r_instr_valid;
  assign w_commit = commit && !r_instr_valid && (r_digit_count == LP_NUM_DIGITS);

  // Digit assembly and handshake; clear beats both a new key and commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instruction <= '0;
      r_digit_count <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_clear) begin
      r_instruction <= '0;
      r_digit_count <= '0;
    end else begin
      if (w_take) begin
        r_instr_valid <= 1'b0;
        r_digit_count <= '0;
      end else if (w_commit) begin
        r_instr_valid <= 1'b1;
      end
      if (w_accept) begin
        r_instruction <= {r_instruction[27:0], w_key_code};
        r_digit_count <= r_digit_count + 4'd1;
      end
    end
  end

  assign key_valid   = w_key_valid;
  assign key_code    = w_key_code;
  assign digit_count = r_digit_count;
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench for hex_keypad_entry with a fast scan divider.
// A behavioural keypad drives col from the active row; a digit-buffer model
// predicts instruction, digit_count and instr_valid.
module tb_hex_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clear;
  logic        commit;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  digit_count;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;

  // Physical keypad: pressed key shorts its row to its column
  logic       pressed;
  logic       glitch;
  logic [1:0] pressRow;
  logic [1:0] pressCol;

  // Reference model of the digit buffer
  logic [31:0] mInstr;
  int          mCount;
  logic        mValid;

  int passCount  = 0;
  int checkCount = 0;
  int kvPulses   = 0;
  logic [3:0] kvLastCode = 4'h0;

  hex_keypad_entry #(
    .SCAN_DIV_BITS  (2),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .clear       (clear),
    .commit      (commit),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .digit_count (digit_count),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // Column lines as seen by the keypad: pulled up unless a pressed key sits on the driven row
  always_comb begin
    col = 4'b1111;
    if (glitch) col = 4'b1110;
    else if (pressed && (row == ~(4'b0001 << pressRow))) col = ~(4'b0001 << pressCol);
  end

  // Count key_valid cycles and remember the code presented with them
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      kvPulses   = kvPulses + 1;
      kvLastCode = key_code;
    end
  end

  // Global time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mInstr = 32'h0; mCount = 0; mValid = 1'b0;
  endtask

  task automatic modelKey(input logic [3:0] k);
    if (!mValid && mCount < 8) begin
      mInstr = (mInstr << 4) | {28'h0, k};
      mCount = mCount + 1;
    end
  endtask

  task automatic modelClear();
    if (!mValid) begin
      mInstr = 32'h0; mCount = 0;
    end
  endtask

  task automatic modelCommit();
    if (!mValid && mCount == 8) mValid = 1'b1;
  endtask

  task automatic modelTake();
    if (mValid) begin
      mValid = 1'b0; mCount = 0;
    end
  endtask

  // Press a key until it is accepted (bounded), optionally pulse clear on the key_valid cycle, then release
  task automatic pressKey(input logic [3:0] k, input bit clearOnValid,
                          output bit seen, output int pulses, output logic [3:0] code);
    int startPulses;
    startPulses = kvPulses;
    seen = 1'b0;
    pressRow = k[3:2];
    pressCol = k[1:0];
    pressed = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (kvPulses != startPulses) seen = 1'b1;
    end
    if (seen && clearOnValid) begin
      clear = 1'b1;
      @(negedge clk); #1;
      clear = 1'b0;
    end
    code = kvLastCode;
    pressed = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    pulses = kvPulses - startPulses;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
    modelClear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    modelReset();
    checkCount++; if (row !== 4'b1110) $display("[TB] FAIL reset_row: got %b expected 1110", row); else passCount++;
    checkCount++; if (key_valid !== 1'b0) $display("[TB] FAIL reset_key_valid: got %b expected 0", key_valid); else passCount++;
    checkCount++; if (key_code !== 4'h0) $display("[TB] FAIL reset_key_code: got %h expected 0", key_code); else passCount++;
    checkCount++; if (digit_count !== 4'd0) $display("[TB] FAIL reset_digit_count: got %0d expected 0", digit_count); else passCount++;
    checkCount++; if (instruction !== 32'h0) $display("[TB] FAIL reset_instruction: got %h expected 0", instruction); else passCount++;
    checkCount++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); else passCount++;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single_key();
    bit seen; int pulses; logic [3:0] code;
    pressKey(4'h9, 1'b0, seen, pulses, code);
    modelKey(4'h9);
    checkCount++; if (!seen) $display("[TB] FAIL single_key_timeout: got no key_valid expected one"); else passCount++;
    checkCount++; if (pulses != 1) $display("[TB] FAIL single_key_pulses: got %0d expected 1", pulses); else passCount++;
    checkCount++; if (code !== 4'h9) $display("[TB] FAIL single_key_code: got %h expected 9", code); else passCount++;
    checkCount++; if (digit_count !== 4'(mCount)) $display("[TB] FAIL single_key_count: got %0d expected %0d", digit_count, mCount); else passCount++;
    checkCount++; if (instruction !== mInstr) $display("[TB] FAIL single_key_instr: got %h expected %h", instruction, mInstr); else passCount++;
  endtask

  task automatic test_glitch();
    int startPulses; int rowChanges; int badRows; logic [3:0] prevRow;
    startPulses = kvPulses;
    glitch = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    glitch = 1'b0;
    rowChanges = 0; badRows = 0;
    prevRow = row;
    repeat (24) begin
      @(negedge clk); #1;
      if (row != prevRow) rowChanges++;
      if (!(row == 4'b1110 || row == 4'b1101 || row == 4'b1011 || row == 4'b0111)) badRows++;
      prevRow = row;
    end
    checkCount++; if (kvPulses != startPulses) $display("[TB] FAIL glitch_no_key: got %0d pulses expected 0", kvPulses - startPulses); else passCount++;
    checkCount++; if (rowChanges < 3) $display("[TB] FAIL glitch_back_to_scan: got %0d row steps expected at least 3", rowChanges); else passCount++;
    checkCount++; if (badRows != 0) $display("[TB] FAIL glitch_row_onehot: got %0d bad row samples expected 0", badRows); else passCount++;
    checkCount++; if (digit_count !== 4'(mCount)) $display("[TB] FAIL glitch_count: got %0d expected %0d", digit_count, mCount); else passCount++;
  endtask

  task automatic test_random_entry();
    bit seen; int pulses; logic [3:0] code; logic [3:0] k; int n;
    pulseClear();
    n = $urandom_range(1, 7);
    for (int i = 0; i < n; i++) begin
      k = 4'($urandom_range(0, 15));
      pressKey(k, 1'b0, seen, pulses, code);
      modelKey(k);
      checkCount++; if (!seen || pulses != 1) $display("[TB] FAIL rand_pulse: got seen=%0d pulses=%0d expected one pulse", seen, pulses); else passCount++;
      checkCount++; if (code !== k) $display("[TB] FAIL rand_code: got %h expected %h", code, k); else passCount++;
      checkCount++; if (instruction !== mInstr) $display("[TB] FAIL rand_instr: got %h expected %h", instruction, mInstr); else passCount++;
      checkCount++; if (digit_count !== 4'(mCount)) $display("[TB] FAIL rand_count: got %0d expected %0d", digit_count, mCount); else passCount++;
    end
    commit = 1'b1;
    @(negedge clk); #1;
    commit = 1'b0;
    modelCommit();
    @(negedge clk); #1;
    checkCount++; if (instr_valid !== mValid) $display("[TB] FAIL early_commit: got %b expected %b", instr_valid, mValid); else passCount++;
    pulseClear();
    checkCount++; if (instruction !== 32'h0 || digit_count !== 4'd0) $display("[TB] FAIL rand_clear: got %h/%0d expected 0/0", instruction, digit_count); else passCount++;
  endtask

  task automatic test_clear_with_key();
    bit seen; int pulses; logic [3:0] code; logic [3:0] k;
    pulseClear();
    for (int i = 0; i < 3; i++) begin
      k = 4'($urandom_range(0, 15));
      pressKey(k, 1'b0, seen, pulses, code);
      modelKey(k);
    end
    checkCount++; if (digit_count !== 4'd3 || instruction !== mInstr) $display("[TB] FAIL pre_clear_state: got %0d/%h expected 3/%h", digit_count, instruction, mInstr); else passCount++;
    k = 4'($urandom_range(0, 15));
    pressKey(k, 1'b1, seen, pulses, code);
    modelClear();
    checkCount++; if (!seen || pulses != 1) $display("[TB] FAIL clear_key_pulse: got seen=%0d pulses=%0d expected one pulse", seen, pulses); else passCount++;
    checkCount++; if (instruction !== 32'h0) $display("[TB] FAIL clear_key_instr: got %h expected 0", instruction); else passCount++;
    checkCount++; if (digit_count !== 4'd0) $display("[TB] FAIL clear_key_count: got %0d expected 0", digit_count); else passCount++;
  endtask

  task automatic test_full_entry();
    bit seen; int pulses; logic [3:0] code; logic [3:0] k;
    logic [3:0] seq [8];
    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    pulseClear();
    for (int i = 0; i < 8; i++) begin
      pressKey(seq[i], 1'b0, seen, pulses, code);
      modelKey(seq[i]);
      checkCount++; if (code !== seq[i] || instruction !== mInstr) $display("[TB] FAIL full_digit: got code %h instr %h expected %h/%h", code, instruction, seq[i], mInstr); else passCount++;
    end
    checkCount++; if (instruction !== 32'h1234ABCD) $display("[TB] FAIL full_instr: got %h expected 1234abcd", instruction); else passCount++;
    k = 4'($urandom_range(0, 15));
    pressKey(k, 1'b0, seen, pulses, code);
    modelKey(k);
    checkCount++; if (!seen || pulses != 1) $display("[TB] FAIL ninth_pulse: got seen=%0d pulses=%0d expected one pulse", seen, pulses); else passCount++;
    checkCount++; if (instruction !== 32'h1234ABCD || digit_count !== 4'd8) $display("[TB] FAIL ninth_dropped: got %h/%0d expected 1234abcd/8", instruction, digit_count); else passCount++;
    commit = 1'b1;
    @(negedge clk); #1;
    commit = 1'b0;
    modelCommit();
    checkCount++; if (instr_valid !== 1'b1) $display("[TB] FAIL commit_valid: got %b expected 1", instr_valid); else passCount++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checkCount++; if (instr_valid !== mValid || instruction !== mInstr) $display("[TB] FAIL hold_stable: got %b/%h expected %b/%h", instr_valid, instruction, mValid, mInstr); else passCount++;
    end
    pulseClear();
    checkCount++; if (instruction !== 32'h1234ABCD || instr_valid !== 1'b1) $display("[TB] FAIL clear_while_valid: got %h/%b expected 1234abcd/1", instruction, instr_valid); else passCount++;
    k = 4'($urandom_range(0, 15));
    pressKey(k, 1'b0, seen, pulses, code);
    modelKey(k);
    checkCount++; if (pulses != 1 || instruction !== mInstr || digit_count !== 4'(mCount)) $display("[TB] FAIL key_while_valid: got %0d/%h/%0d expected 1/%h/%0d", pulses, instruction, digit_count, mInstr, mCount); else passCount++;
    instr_ready = 1'b1;
    @(negedge clk); #1;
    instr_ready = 1'b0;
    modelTake();
    checkCount++; if (instr_valid !== 1'b0) $display("[TB] FAIL take_valid: got %b expected 0", instr_valid); else passCount++;
    checkCount++; if (digit_count !== 4'd0) $display("[TB] FAIL take_count: got %0d expected 0", digit_count); else passCount++;
    checkCount++; if (instruction !== 32'h1234ABCD) $display("[TB] FAIL take_retain: got %h expected 1234abcd", instruction); else passCount++;
  endtask

  task automatic test_commit_clear();
    bit seen; int pulses; logic [3:0] code; logic [3:0] k;
    pulseClear();
    for (int i = 0; i < 8; i++) begin
      k = 4'($urandom_range(0, 15));
      pressKey(k, 1'b0, seen, pulses, code);
      modelKey(k);
    end
    checkCount++; if (digit_count !== 4'd8 || instruction !== mInstr) $display("[TB] FAIL fill_eight: got %0d/%h expected 8/%h", digit_count, instruction, mInstr); else passCount++;
    commit = 1'b1;
    clear  = 1'b1;
    @(negedge clk); #1;
    commit = 1'b0;
    clear  = 1'b0;
    modelClear();
    @(negedge clk); #1;
    checkCount++; if (instr_valid !== 1'b0) $display("[TB] FAIL commit_clear_valid: got %b expected 0", instr_valid); else passCount++;
    checkCount++; if (instruction !== 32'h0 || digit_count !== 4'd0) $display("[TB] FAIL commit_clear_state: got %h/%0d expected 0/0", instruction, digit_count); else passCount++;
  endtask

  task automatic test_reset_mid_debounce();
    bit seen; int pulses; logic [3:0] code; logic [3:0] k; logic [1:0] idx; int startPulses;
    for (int i = 0; i < 2; i++) begin
      k = 4'($urandom_range(1, 15));
      pressKey(k, 1'b0, seen, pulses, code);
      modelKey(k);
    end
    @(negedge clk); #1;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (row == ~(4'b0001 << i)) idx = 2'(i);
    startPulses = kvPulses;
    pressRow = idx;
    pressCol = 2'($urandom_range(0, 3));
    pressed = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkCount++; if (row !== ~(4'b0001 << idx) || kvPulses != startPulses) $display("[TB] FAIL debounce_frozen: got row %b pulses %0d expected row %b pulses 0", row, kvPulses - startPulses, ~(4'b0001 << idx)); else passCount++;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkCount++; if (row !== 4'b1110) $display("[TB] FAIL async_row: got %b expected 1110", row); else passCount++;
    checkCount++; if (key_valid !== 1'b0 || key_code !== 4'h0) $display("[TB] FAIL async_key: got %b/%h expected 0/0", key_valid, key_code); else passCount++;
    checkCount++; if (digit_count !== 4'd0 || instruction !== 32'h0 || instr_valid !== 1'b0) $display("[TB] FAIL async_buffer: got %0d/%h/%b expected 0/0/0", digit_count, instruction, instr_valid); else passCount++;
    pressed = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    checkCount++; if (kvPulses != startPulses) $display("[TB] FAIL post_reset_key: got %0d pulses expected 0", kvPulses - startPulses); else passCount++;
    checkCount++; if (digit_count !== 4'(mCount) || instruction !== mInstr) $display("[TB] FAIL post_reset_state: got %0d/%h expected %0d/%h", digit_count, instruction, mCount, mInstr); else passCount++;
  endtask

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    commit      = 1'b0;
    instr_ready = 1'b0;
    pressed     = 1'b0;
    glitch      = 1'b0;
    pressRow    = 2'd0;
    pressCol    = 2'd0;
    modelReset();
    test_reset();
    test_single_key();
    test_glitch();
    test_random_entry();
    test_clear_with_key();
    test_full_entry();
    test_commit_clear();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
